// File: rtl/buffer_swap_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : buf_swap_pkg
// Brief    : Shared types and constants for the double-buffer swap controller.
// Revision : 1.0
// ============================================================================
package buf_swap_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 8;

    localparam logic BANK_RAM1 = 1'b0;
    localparam logic BANK_RAM2 = 1'b1;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_FILL = 2'd1,
        W_DONE = 2'd2
    } wr_state_e;

endpackage
`default_nettype wire

// File: rtl/buffer_swap_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : buffer_swap_ctrl_if
// Brief    : Producer, display and bank-RAM signals of the swap controller.
//            Statistics outputs exist only when BUF_SWAP_STATS_EN is defined.
// Revision : 1.0
// ============================================================================
interface buffer_swap_ctrl_if #(
    parameter int ADDR_W = buf_swap_pkg::ADDR_W_DEF,
    parameter int DATA_W = buf_swap_pkg::DATA_W_DEF
) ();
    logic              wr_start;
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              frame_end;
    logic              rd_req;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              ram1_we;
    logic              ram1_re;
    logic              ram2_we;
    logic              ram2_re;
    logic [ADDR_W-1:0] ram1_addr;
    logic [ADDR_W-1:0] ram2_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram1_rdata;
    logic [DATA_W-1:0] ram2_rdata;
    logic              front_sel;
`ifdef BUF_SWAP_STATS_EN
    logic [15:0]       swap_cnt;
    logic [15:0]       late_cnt;
`endif

    modport slave (
        input  wr_start, wr_valid, wr_data, frame_end, rd_req,
        input  ram1_rdata, ram2_rdata,
        output wr_ready, rd_valid, rd_data,
        output ram1_we, ram1_re, ram2_we, ram2_re,
        output ram1_addr, ram2_addr, ram_wdata, front_sel
`ifdef BUF_SWAP_STATS_EN
        , output swap_cnt, late_cnt
`endif
    );

    modport master (
        output wr_start, wr_valid, wr_data, frame_end, rd_req,
        output ram1_rdata, ram2_rdata,
        input  wr_ready, rd_valid, rd_data,
        input  ram1_we, ram1_re, ram2_we, ram2_re,
        input  ram1_addr, ram2_addr, ram_wdata, front_sel
`ifdef BUF_SWAP_STATS_EN
        , input swap_cnt, late_cnt
`endif
    );
endinterface
`default_nettype wire

// File: rtl/buffer_swap_ctrl_wr_fsm.sv
`default_nettype none
// ============================================================================
// Module   : buf_swap_wr_fsm
// Brief    : Back-bank fill sequencer and owner of the front-bank select.
//            Swap/late counters present with BUF_SWAP_STATS_EN.
// Revision : 1.0
// ============================================================================
module buf_swap_wr_fsm
    import buf_swap_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              wr_start_i,
    input  wire logic              wr_valid_i,
    input  wire logic              frame_end_i,
    output logic [ADDR_W-1:0]      wr_addr_o,
    output logic                   wr_ready_o,
    output logic                   front_sel_o
`ifdef BUF_SWAP_STATS_EN
    ,
    output logic [15:0]            swap_cnt_o,
    output logic [15:0]            late_cnt_o
`endif
);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    wr_state_e         state_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic              wr_ready_q;
    logic              front_sel_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= W_IDLE;
            wr_addr_q   <= '0;
            wr_ready_q  <= 1'b0;
            front_sel_q <= BANK_RAM1;
        end else begin
            case (state_q)
                W_IDLE: begin
                    if (wr_start_i) begin
                        state_q    <= W_FILL;
                        wr_addr_q  <= '0;
                        wr_ready_q <= 1'b1;
                    end
                end
                W_FILL: begin
                    if (wr_valid_i && wr_ready_q) begin
                        wr_addr_q <= wr_addr_q + 1'b1;
                        if (wr_addr_q == ADDR_LAST) begin
                            state_q    <= W_DONE;
                            wr_ready_q <= 1'b0;
                        end
                    end
                end
                W_DONE: begin
                    // The display boundary is the only point where banks change roles
                    if (frame_end_i) begin
                        front_sel_q <= ~front_sel_q;
                        state_q     <= W_IDLE;
                    end
                end
                default: begin
                    state_q    <= W_IDLE;
                    wr_ready_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef BUF_SWAP_STATS_EN
    logic [15:0] swap_cnt_q;
    logic [15:0] late_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            swap_cnt_q <= '0;
            late_cnt_q <= '0;
        end else begin
            if (state_q == W_DONE && frame_end_i && swap_cnt_q != 16'hFFFF)
                swap_cnt_q <= swap_cnt_q + 16'd1;
            if (state_q == W_FILL && frame_end_i && late_cnt_q != 16'hFFFF)
                late_cnt_q <= late_cnt_q + 16'd1;
        end
    end

    assign swap_cnt_o = swap_cnt_q;
    assign late_cnt_o = late_cnt_q;
`endif

    assign wr_addr_o   = wr_addr_q;
    assign wr_ready_o  = wr_ready_q;
    assign front_sel_o = front_sel_q;

endmodule
`default_nettype wire

// File: rtl/buffer_swap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : buffer_swap_ctrl
// Brief    : Double-buffered frame store controller: fill back bank, replay
//            front bank, swap on frame end. Option: BUF_SWAP_STATS_EN.
// Revision : 1.0
// ============================================================================
module buffer_swap_ctrl
    import buf_swap_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  wire logic          clk,
    input  wire logic          reset,
    buffer_swap_ctrl_if.slave  bus
);
    logic [ADDR_W-1:0] w_wr_addr;
    logic              w_wr_ready;
    logic              w_front_sel;

    buf_swap_wr_fsm #(.ADDR_W(ADDR_W)) u_wr_fsm (
        .clk         (clk),
        .reset       (reset),
        .wr_start_i  (bus.wr_start),
        .wr_valid_i  (bus.wr_valid),
        .frame_end_i (bus.frame_end),
        .wr_addr_o   (w_wr_addr),
        .wr_ready_o  (w_wr_ready),
        .front_sel_o (w_front_sel)
`ifdef BUF_SWAP_STATS_EN
        ,
        .swap_cnt_o  (bus.swap_cnt),
        .late_cnt_o  (bus.late_cnt)
`endif
    );

    logic              w_wr_fire;
    logic              w_rd_fire;
    logic              w_ram1_we, w_ram2_we, w_ram1_re, w_ram2_re;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] ram1_addr_q, ram1_addr_d;
    logic [ADDR_W-1:0] ram2_addr_q, ram2_addr_d;
    logic              rd_valid_q;
    logic              rd_sel_q;

    assign w_wr_fire = bus.wr_valid & w_wr_ready;
    assign w_rd_fire = bus.rd_req & ~bus.frame_end;

    // Writes go only to the back bank, reads only to the front bank
    assign w_ram1_we = w_wr_fire & (w_front_sel == BANK_RAM2);
    assign w_ram2_we = w_wr_fire & (w_front_sel == BANK_RAM1);
    assign w_ram1_re = w_rd_fire & (w_front_sel == BANK_RAM1);
    assign w_ram2_re = w_rd_fire & (w_front_sel == BANK_RAM2);

    always_comb begin
        ram1_addr_d = ram1_addr_q;
        ram2_addr_d = ram2_addr_q;
        if (w_ram1_we)      ram1_addr_d = w_wr_addr;
        else if (w_ram1_re) ram1_addr_d = rd_addr_q;
        if (w_ram2_we)      ram2_addr_d = w_wr_addr;
        else if (w_ram2_re) ram2_addr_d = rd_addr_q;

        rd_addr_d = rd_addr_q;
        if (bus.frame_end)   rd_addr_d = '0;
        else if (bus.rd_req) rd_addr_d = rd_addr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_addr_q   <= '0;
            ram1_addr_q <= '0;
            ram2_addr_q <= '0;
            rd_valid_q  <= 1'b0;
            rd_sel_q    <= BANK_RAM1;
        end else begin
            rd_addr_q   <= rd_addr_d;
            ram1_addr_q <= ram1_addr_d;
            ram2_addr_q <= ram2_addr_d;
            rd_valid_q  <= w_rd_fire;
            if (w_rd_fire)
                rd_sel_q <= w_front_sel;
        end
    end

    assign bus.wr_ready  = w_wr_ready;
    assign bus.front_sel = w_front_sel;
    assign bus.ram1_we   = w_ram1_we;
    assign bus.ram2_we   = w_ram2_we;
    assign bus.ram1_re   = w_ram1_re;
    assign bus.ram2_re   = w_ram2_re;
    assign bus.ram1_addr = ram1_addr_d;
    assign bus.ram2_addr = ram2_addr_d;
    assign bus.ram_wdata = bus.wr_data;
    assign bus.rd_valid  = rd_valid_q;
    // Bank data arrives one cycle after re; steer by the bank latched with the request
    assign bus.rd_data   = rd_valid_q ? ((rd_sel_q == BANK_RAM2) ? bus.ram2_rdata
                                                                 : bus.ram1_rdata)
                                      : '0;

endmodule
`default_nettype wire

// File: doc/buffer_swap_ctrl.md
BUFFER_SWAP_CTRL -- requirements
Module: buffer_swap_ctrl

Interface
REQ-001 Parameter ADDR_W, default 5, address width of each bank; a frame is 2^ADDR_W entries.
REQ-002 Parameter DATA_W, default 8, sample width.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 wr_start  in  1  producer requests to begin filling the back bank.
REQ-007 wr_valid / wr_data  in  1 / DATA_W  producer sample.
REQ-008 wr_ready  out  1  high only while filling.
REQ-009 frame_end  in  1  one-cycle pulse when the display finishes a frame.
REQ-010 rd_req  in  1  display requests the next front-bank sample.
REQ-011 rd_valid / rd_data  out  1 / DATA_W  read response.
REQ-012 ram1_we, ram1_re, ram2_we, ram2_re  out  1 each  bank strobes.
REQ-013 ram1_addr, ram2_addr  out  ADDR_W each  bank addresses.
REQ-014 ram_wdata  out  DATA_W  write data shared by both banks.
REQ-015 ram1_rdata, ram2_rdata  in  DATA_W  bank read data; 1-cycle read latency.
REQ-016 front_sel  out  1  0 = ram1 front, 1 = ram2 front.

Function
REQ-017 The writer FSM SHALL have states W_IDLE, W_FILL and W_DONE.
REQ-018 W_IDLE + wr_start -> W_FILL with wr_addr = 0; wr_start in any other state SHALL be ignored.
REQ-019 In W_FILL, wr_ready=1; each wr_valid&&wr_ready cycle SHALL assert we of the back bank (!front_sel) at wr_addr with ram_wdata=wr_data, then increment wr_addr.
REQ-020 The write at wr_addr = 2^ADDR_W-1 SHALL move W_FILL -> W_DONE.
REQ-021 In W_DONE, frame_end SHALL toggle front_sel and return to W_IDLE; this is the only swap point.
REQ-022 frame_end in W_IDLE or W_FILL SHALL NOT swap; the front bank replays and a fill in progress continues.
REQ-023 rd_addr SHALL reset to 0 on every frame_end and wrap from 2^ADDR_W-1 to 0.
REQ-024 rd_req (not in a frame_end cycle) SHALL assert re of the front bank at rd_addr and increment rd_addr; rd_valid SHALL assert the next cycle, with rd_data taken from the bank selected at request time.
REQ-025 rd_req in a frame_end cycle SHALL be ignored (no re, no rd_valid).
REQ-026 The front bank SHALL never be written and the back bank never read; the inactive bank's strobes SHALL be 0.
REQ-027 Unused bank addresses SHALL hold their last value; ram_wdata is don't-care when no we is asserted.

Reset
REQ-028 Reset SHALL set front_sel=0, state W_IDLE, wr_addr=rd_addr=0, all we/re=0, wr_ready=0, rd_valid=0, rd_data=0, and both counters to 0.
REQ-029 Reset during W_FILL SHALL abandon the fill; the back-bank contents become undefined, and a read issued the cycle before reset SHALL NOT produce rd_valid afterwards.

Configuration
REQ-030 With BUF_SWAP_STATS_EN defined, the outputs swap_cnt[15:0] and late_cnt[15:0] SHALL exist.
REQ-031 swap_cnt SHALL increment on each swap; late_cnt SHALL increment on each frame_end in W_FILL; both SHALL saturate at 16'hFFFF.
REQ-032 Without BUF_SWAP_STATS_EN, these ports and counters SHALL be absent and behaviour is otherwise identical.

Structure
REQ-033 Package buf_swap_pkg SHALL hold the writer-state enum, BANK_RAM1/BANK_RAM2 constants and the default ADDR_W/DATA_W.
REQ-034 The writer FSM SHALL be the sub-module buf_swap_wr_fsm; the read path and bank muxing stay in the top.

Verification
REQ-035 Reset, then 2 idle cycles -> front_sel=0, all strobes 0, wr_ready=0, rd_valid=0.
REQ-036 wr_start, then 32 writes of data = addr -> ram2_we pulses at addresses 0..31, state W_DONE, wr_ready=0; a following frame_end -> front_sel=1.
REQ-037 After REQ-036, 32 rd_req -> ram2_re at addresses 0..31, rd_data 0..31 each one cycle later, and rd_addr wraps to 0.
REQ-038 frame_end after 10 of 32 writes -> front_sel unchanged, the fill continues, late_cnt=1 (stats build).
REQ-039 rd_req coincident with frame_end -> no re, no rd_valid next cycle; the next rd_req reads address 0.
REQ-040 Reset asserted mid-fill at wr_addr=17 -> W_IDLE, front_sel=0, wr_addr=0, no further we.
